wtlb_miss_ctl: RTL and testbench
================================

WTLB_MISS_CTL -- requirements
Module: wtlb_miss_ctl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning miss FIFO entries (power of 2).
REQ-002 SHALL have parameter MAX_RETRY, default 3, meaning walk+replay attempts per miss before a fault is reported.
REQ-003 SHALL have the following ports; clock and reset first:
- clk  in  1  single clock, all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- except  in  1  pipeline flush.
- miss_en  in  1  store-AGU tlbMiss pulse.
- miss_addr  in  44  missed virtual address.
- miss_attr  in  4  attributes of the missed op.
- miss_proc  in  21  process id (proc[20:0]).
- full  out  1  FIFO occupancy == DEPTH.
- overflow  out  1  one-cycle pulse: miss_en dropped because full.
- walk_req  out  1  walk request, level, held until ack.
- walk_addr  out  52  {proc, vaddr[43:13]}, stable while walk_req=1.
- walk_ack  in  1  walker accepted request.
- walk_done  in  1  walk finished, one-cycle pulse.
- walk_fault  in  1  qualifies walk_done: no valid translation.
- bus_hold  out  1  stalls the store AGU during replay.
- mex_en  out  1  replay strobe into the AGU.
- mex_addr  out  44  replay address.
- mex_attr  out  4  replay attributes.
- tlb_hit  in  1  TLB hit for the replayed lookup.
- fault_en  out  1  one-cycle pulse, unresolvable miss.
- fault_addr  out  44  address of the faulting miss, valid with fault_en.

Function
REQ-004 SHALL push {miss_addr, miss_attr, miss_proc} on miss_en when count<DEPTH and except=0.
REQ-005 SHALL ignore miss_en when full, even if a pop occurs in the same cycle, and SHALL pulse overflow in the following cycle.
REQ-006 SHALL keep pointers log2(DEPTH) bits wide, wrapping modulo DEPTH, and a count of log2(DEPTH)+1 bits; simultaneous push and pop leaves count unchanged.
REQ-007 SHALL implement FSM states IDLE, REQ, WAIT, HOLD, REPLAY, CHECK, DRAIN, always operating on the FIFO head.
REQ-008 IDLE: when count!=0, SHALL load retry=0 and go to REQ the next cycle.
REQ-009 REQ: walk_req=1 with walk_addr={head.proc, head.addr[43:13]}; on walk_ack SHALL go to WAIT, and walk_req drops the same edge.
REQ-010 WAIT: walk_done & ~walk_fault SHALL go to HOLD.
REQ-011 WAIT: walk_done & walk_fault SHALL pulse fault_en with fault_addr=head.addr, pop the head, and go to IDLE.
REQ-012 HOLD: bus_hold=1 for exactly one cycle, then SHALL go to REPLAY, giving the AGU one cycle to register the hold.
REQ-013 REPLAY: mex_en=1 and bus_hold=1 for one cycle, with mex_addr=head.addr and mex_attr=head.attr; SHALL then go to CHECK.
REQ-014 mex_addr and mex_attr SHALL be 0 whenever mex_en=0.
REQ-015 CHECK: bus_hold=1 and tlb_hit sampled. tlb_hit=1 SHALL pop the head and go to IDLE. tlb_hit=0 with retry+1<MAX_RETRY SHALL increment retry and go to REQ. Otherwise SHALL pulse fault_en, pop, and go to IDLE.
REQ-016 bus_hold SHALL be 1 only in HOLD, REPLAY and CHECK.
REQ-017 except SHALL empty the FIFO (pointers and count to 0) and drop any same-cycle push. The next state SHALL be DRAIN if the current state is WAIT, or REQ with walk_ack=1; otherwise IDLE. No fault_en or mex_en is issued for flushed entries.
REQ-018 DRAIN: SHALL wait for walk_done, discard the result, and go to IDLE. A walk_done arriving in the flush cycle itself SHALL go straight to IDLE.
REQ-019 walk_req, mex_en, bus_hold, fault_en and overflow SHALL be registered outputs, with no combinational path from any input.

Reset
REQ-020 rst=0 SHALL immediately force: state=IDLE, count=0, pointers=0, retry=0, full=0, overflow=0, walk_req=0, walk_addr=0, bus_hold=0, mex_en=0, mex_addr=0, mex_attr=0, fault_en=0, fault_addr=0.
REQ-021 Reset asserted mid-walk SHALL abandon the walk; a walk_done pulse after reset release SHALL be ignored in IDLE.
REQ-022 FIFO data storage SHALL need no reset; outputs SHALL not depend on unwritten entries.

Verification
REQ-023 Single hit: miss_addr=0x123_4567_8000 -> walk_req with walk_addr[30:0]=0x091A2B3C; ack; done, no fault. Then bus_hold rises, mex_en 1 cycle later with mex_addr=0x12345678000, tlb_hit=1, FIFO empty, bus_hold=0.
REQ-024 Walk fault: walk_done with walk_fault=1 -> fault_en=1 for 1 cycle, fault_addr=miss_addr, no mex_en, count=0.
REQ-025 Retry exhaustion: tlb_hit=0 on every CHECK -> exactly 3 walk_req/mex_en rounds, then 1 fault_en.
REQ-026 Overflow: 5 back-to-back miss_en while the walker stalls ack -> full=1 after the 4th, overflow pulse for the 5th, entries replayed in order 1..4.
REQ-027 Flush in WAIT: except=1 with 3 entries -> count=0 and DRAIN; walk_done -> IDLE, no mex_en, no fault_en.
REQ-028 Async reset: rst=0 during REPLAY -> mex_en and bus_hold go to 0 without a clock edge, all outputs at reset values.

Source files
------------

// File: rtl/wtlb_miss_ctl.sv
// Store-side TLB miss controller: queues AGU misses, drives the page walker for
// the oldest one, then replays it into the AGU under a bus hold until it hits or faults.
module wtlb_miss_ctl #(
    parameter int DEPTH     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        except,
    input  logic        miss_en,
    input  logic [43:0] miss_addr,
    input  logic [3:0]  miss_attr,
    input  logic [20:0] miss_proc,
    output logic        full,
    output logic        overflow,
    output logic        walk_req,
    output logic [51:0] walk_addr,
    input  logic        walk_ack,
    input  logic        walk_done,
    input  logic        walk_fault,
    output logic        bus_hold,
    output logic        mex_en,
    output logic [43:0] mex_addr,
    output logic [3:0]  mex_attr,
    input  logic        tlb_hit,
    output logic        fault_en,
    output logic [43:0] fault_addr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

    typedef struct packed {
        logic [43:0] addr;
        logic [3:0]  attr;
        logic [20:0] proc;
    } miss_t;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, REPLAY, CHECK, DRAIN} state_t;

    miss_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [RW-1:0]  retry;
    state_t         state;

    miss_t head;
    logic  push, pop, retry_left, drain_walk;

    assign head       = mem[rd_ptr];
    assign full       = (count == DEPTH_C);
    assign push       = miss_en & ~full & ~except;
    assign retry_left = (retry < RETRY_LAST);
    assign pop        = ~except & (((state == WAIT) & walk_done & walk_fault) |
                                   ((state == CHECK) & (tlb_hit | ~retry_left)));
    // An accepted walk still owes us a walk_done; wait it out unless it is arriving now.
    assign drain_walk = (((state == WAIT) | (state == DRAIN)) & ~walk_done) |
                        ((state == REQ) & walk_ack);

    // Entry storage carries no reset; only slots behind a valid count are ever read.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{addr: miss_addr, attr: miss_attr, proc: miss_proc};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= miss_en & full & ~except;
            if (except) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            retry      <= '0;
            walk_req   <= 1'b0;
            walk_addr  <= '0;
            bus_hold   <= 1'b0;
            mex_en     <= 1'b0;
            mex_addr   <= '0;
            mex_attr   <= '0;
            fault_en   <= 1'b0;
            fault_addr <= '0;
        end else begin
            fault_en <= 1'b0;
            mex_en   <= 1'b0;
            mex_addr <= '0;
            mex_attr <= '0;
            if (except) begin
                state    <= drain_walk ? DRAIN : IDLE;
                walk_req <= 1'b0;
                bus_hold <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (count != '0) begin
                            retry     <= '0;
                            state     <= REQ;
                            walk_req  <= 1'b1;
                            walk_addr <= {head.proc, head.addr[43:13]};
                        end
                    end
                    REQ: begin
                        if (walk_ack) begin
                            state    <= WAIT;
                            walk_req <= 1'b0;
                        end
                    end
                    WAIT: begin
                        if (walk_done) begin
                            if (walk_fault) begin
                                fault_en   <= 1'b1;
                                fault_addr <= head.addr;
                                state      <= IDLE;
                            end else begin
                                state    <= HOLD;
                                bus_hold <= 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        state    <= REPLAY;
                        mex_en   <= 1'b1;
                        mex_addr <= head.addr;
                        mex_attr <= head.attr;
                    end
                    REPLAY: state <= CHECK;
                    CHECK: begin
                        bus_hold <= 1'b0;
                        if (tlb_hit) begin
                            state <= IDLE;
                        end else if (retry_left) begin
                            retry     <= retry + RW'(1);
                            state     <= REQ;
                            walk_req  <= 1'b1;
                            walk_addr <= {head.proc, head.addr[43:13]};
                        end else begin
                            fault_en   <= 1'b1;
                            fault_addr <= head.addr;
                            state      <= IDLE;
                        end
                    end
                    DRAIN: begin
                        if (walk_done) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_wtlb_miss_ctl.sv
// Directed bench for wtlb_miss_ctl: hit, walk fault, retry exhaustion, overflow,
// flush and asynchronous reset scenarios with hand-computed expectations.
module tb_wtlb_miss_ctl;
    logic        clk = 1'b0;
    logic        rst, except, miss_en;
    logic [43:0] miss_addr;
    logic [3:0]  miss_attr;
    logic [20:0] miss_proc;
    logic        full, overflow, walk_req;
    logic [51:0] walk_addr;
    logic        walk_ack, walk_done, walk_fault;
    logic        bus_hold, mex_en;
    logic [43:0] mex_addr;
    logic [3:0]  mex_attr;
    logic        tlb_hit, fault_en;
    logic [43:0] fault_addr;

    int checks = 0;
    int errors = 0;
    int mon_mex, mon_fault, mon_req;
    logic req_prev = 1'b0;
    logic [43:0] mex_log [$];

    wtlb_miss_ctl #(.DEPTH(4), .MAX_RETRY(3)) dut (
        .clk(clk), .rst(rst), .except(except),
        .miss_en(miss_en), .miss_addr(miss_addr), .miss_attr(miss_attr), .miss_proc(miss_proc),
        .full(full), .overflow(overflow),
        .walk_req(walk_req), .walk_addr(walk_addr), .walk_ack(walk_ack),
        .walk_done(walk_done), .walk_fault(walk_fault),
        .bus_hold(bus_hold), .mex_en(mex_en), .mex_addr(mex_addr), .mex_attr(mex_attr),
        .tlb_hit(tlb_hit), .fault_en(fault_en), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    // Event monitor on the inactive edge.
    always @(negedge clk) begin
        if (mex_en) begin
            mon_mex++;
            mex_log.push_back(mex_addr);
        end
        if (fault_en) mon_fault++;
        if (walk_req && !req_prev) mon_req++;
        req_prev = walk_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        mon_mex = 0;
        mon_fault = 0;
        mon_req = 0;
        mex_log.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0; except = 1'b0; miss_en = 1'b0;
        miss_addr = '0; miss_attr = '0; miss_proc = '0;
        walk_ack = 1'b0; walk_done = 1'b0; walk_fault = 1'b0; tlb_hit = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        clr_mon();
    endtask

    // Cooperative walker: ack any pending request, complete it one cycle later.
    task automatic run_walker(input int cycles, input logic hit, input logic fault);
        logic ack_q = 1'b0;
        tlb_hit = hit;
        walk_fault = fault;
        for (int i = 0; i < cycles; i++) begin
            walk_done = ack_q;
            walk_ack  = walk_req;
            ack_q     = walk_ack;
            tick();
        end
        walk_ack = 1'b0; walk_done = 1'b0; walk_fault = 1'b0; tlb_hit = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({walk_req, bus_hold, mex_en, fault_en, full, overflow} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {walk_req, bus_hold, mex_en, fault_en, full, overflow});
        end
        checks++;
        if ({walk_addr, mex_addr, mex_attr, fault_addr} !== '0) begin
            errors++;
            $display("FAIL reset_data: walk_addr=%h mex_addr=%h mex_attr=%h fault_addr=%h expected 0",
                     walk_addr, mex_addr, mex_attr, fault_addr);
        end
        checks++;
        if (dut.count !== 3'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", dut.count);
        end
    endtask

    task automatic test_single_hit();
        do_reset();
        miss_addr = 44'h123_4567_8000; miss_attr = 4'h5; miss_proc = 21'h0ABCDE;
        miss_en = 1'b1; tick();
        miss_en = 1'b0; tick();
        checks++;
        if (walk_req !== 1'b1 || walk_addr[30:0] !== 31'h091A2B3C || walk_addr[51:31] !== 21'h0ABCDE) begin
            errors++;
            $display("FAIL hit_walk_req: req=%b addr=%h expected req=1 addr=%h",
                     walk_req, walk_addr, {21'h0ABCDE, 31'h091A2B3C});
        end
        walk_ack = 1'b1; tick();
        walk_ack = 1'b0;
        checks++;
        if (walk_req !== 1'b0) begin
            errors++;
            $display("FAIL hit_req_drop: walk_req=%b expected 0", walk_req);
        end
        walk_done = 1'b1; tick();
        walk_done = 1'b0;
        checks++;
        if (bus_hold !== 1'b1 || mex_en !== 1'b0 || mex_addr !== 44'h0) begin
            errors++;
            $display("FAIL hit_hold: bus_hold=%b mex_en=%b mex_addr=%h expected 1 0 0",
                     bus_hold, mex_en, mex_addr);
        end
        tick();
        checks++;
        if (mex_en !== 1'b1 || bus_hold !== 1'b1 || mex_addr !== 44'h123_4567_8000 || mex_attr !== 4'h5) begin
            errors++;
            $display("FAIL hit_replay: mex_en=%b hold=%b addr=%h attr=%h expected 1 1 12345678000 5",
                     mex_en, bus_hold, mex_addr, mex_attr);
        end
        tlb_hit = 1'b1; tick();
        checks++;
        if (mex_en !== 1'b0 || mex_addr !== 44'h0 || mex_attr !== 4'h0 || bus_hold !== 1'b1) begin
            errors++;
            $display("FAIL hit_check: mex_en=%b addr=%h attr=%h hold=%b expected 0 0 0 1",
                     mex_en, mex_addr, mex_attr, bus_hold);
        end
        tick();
        tlb_hit = 1'b0;
        checks++;
        if (bus_hold !== 1'b0 || dut.count !== 3'd0 || full !== 1'b0) begin
            errors++;
            $display("FAIL hit_done: hold=%b count=%0d full=%b expected 0 0 0", bus_hold, dut.count, full);
        end
        repeat (4) tick();
        checks++;
        if (mon_mex !== 1 || mon_fault !== 0 || mon_req !== 1) begin
            errors++;
            $display("FAIL hit_events: mex=%0d fault=%0d req=%0d expected 1 0 1", mon_mex, mon_fault, mon_req);
        end
    endtask

    task automatic test_walk_fault();
        do_reset();
        miss_addr = 44'h0AB_CDEF_0123; miss_attr = 4'h9; miss_proc = 21'h000033;
        miss_en = 1'b1; tick();
        miss_en = 1'b0; tick();
        walk_ack = 1'b1; tick();
        walk_ack = 1'b0; walk_done = 1'b1; walk_fault = 1'b1; tick();
        walk_done = 1'b0; walk_fault = 1'b0;
        checks++;
        if (fault_en !== 1'b1 || fault_addr !== 44'h0AB_CDEF_0123 || dut.count !== 3'd0 || bus_hold !== 1'b0) begin
            errors++;
            $display("FAIL fault_pulse: en=%b addr=%h count=%0d hold=%b expected 1 0abcdef0123 0 0",
                     fault_en, fault_addr, dut.count, bus_hold);
        end
        tick();
        checks++;
        if (fault_en !== 1'b0) begin
            errors++;
            $display("FAIL fault_width: fault_en=%b expected 0", fault_en);
        end
        repeat (3) tick();
        checks++;
        if (mon_mex !== 0 || mon_fault !== 1 || walk_req !== 1'b0) begin
            errors++;
            $display("FAIL fault_events: mex=%0d fault=%0d req=%b expected 0 1 0", mon_mex, mon_fault, walk_req);
        end
    endtask

    task automatic test_retry_exhaust();
        do_reset();
        miss_addr = 44'h777_0000_2000; miss_attr = 4'h3; miss_proc = 21'h1FFFFF;
        miss_en = 1'b1; tick();
        miss_en = 1'b0;
        run_walker(40, 1'b0, 1'b0);
        checks++;
        if (mon_req !== 3 || mon_mex !== 3 || mon_fault !== 1) begin
            errors++;
            $display("FAIL retry_rounds: req=%0d mex=%0d fault=%0d expected 3 3 1", mon_req, mon_mex, mon_fault);
        end
        checks++;
        if (fault_addr !== 44'h777_0000_2000 || dut.count !== 3'd0) begin
            errors++;
            $display("FAIL retry_fault_addr: addr=%h count=%0d expected 77700002000 0", fault_addr, dut.count);
        end
    endtask

    task automatic test_overflow();
        logic [43:0] ea [5];
        do_reset();
        for (int i = 0; i < 5; i++) ea[i] = 44'h100_0000_0000 + 44'(i + 1) * 44'h2000;
        for (int i = 0; i < 5; i++) begin
            miss_addr = ea[i]; miss_attr = 4'(i); miss_proc = 21'(i);
            miss_en = 1'b1; tick();
            if (i == 2) begin
                checks++;
                if (full !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_not_full: full=%b expected 0 after 3 pushes", full);
                end
            end
            if (i == 3) begin
                checks++;
                if (full !== 1'b1 || overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_full: full=%b overflow=%b expected 1 0", full, overflow);
                end
            end
            if (i == 4) begin
                checks++;
                if (overflow !== 1'b1 || full !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_pulse: overflow=%b full=%b expected 1 1", overflow, full);
                end
            end
        end
        miss_en = 1'b0; tick();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_width: overflow=%b expected 0", overflow);
        end
        run_walker(60, 1'b1, 1'b0);
        checks++;
        if (mex_log.size() !== 4 || mon_fault !== 0 || dut.count !== 3'd0 || full !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drain: replays=%0d faults=%0d count=%0d full=%b expected 4 0 0 0",
                     mex_log.size(), mon_fault, dut.count, full);
        end
        for (int i = 0; i < 4 && i < mex_log.size(); i++) begin
            checks++;
            if (mex_log[i] !== ea[i]) begin
                errors++;
                $display("FAIL ovf_order[%0d]: got %h expected %h", i, mex_log[i], ea[i]);
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            miss_addr = 44'h200_0000_0000 + 44'(i) * 44'h4000; miss_attr = 4'hA; miss_proc = 21'h5;
            miss_en = 1'b1; tick();
        end
        miss_en = 1'b0;
        walk_ack = 1'b1; tick();
        walk_ack = 1'b0;
        checks++;
        if (dut.state !== 3'd2 || dut.count !== 3'd3) begin
            errors++;
            $display("FAIL flush_pre: state=%0d count=%0d expected 2 3", dut.state, dut.count);
        end
        except = 1'b1; miss_en = 1'b1; tick();
        except = 1'b0; miss_en = 1'b0;
        checks++;
        if (dut.count !== 3'd0 || dut.state !== 3'd6 || full !== 1'b0 || walk_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_drain: count=%0d state=%0d full=%b req=%b expected 0 6 0 0",
                     dut.count, dut.state, full, walk_req);
        end
        repeat (3) tick();
        checks++;
        if (dut.state !== 3'd6 || walk_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_hold: state=%0d req=%b expected 6 0", dut.state, walk_req);
        end
        walk_done = 1'b1; tick();
        walk_done = 1'b0;
        checks++;
        if (dut.state !== 3'd0) begin
            errors++;
            $display("FAIL flush_idle: state=%0d expected 0", dut.state);
        end
        repeat (4) tick();
        checks++;
        if (mon_mex !== 0 || mon_fault !== 0 || mon_req !== 1) begin
            errors++;
            $display("FAIL flush_events: mex=%0d fault=%0d req=%0d expected 0 0 1", mon_mex, mon_fault, mon_req);
        end
        // walk_done landing in the flush cycle goes straight to IDLE.
        miss_addr = 44'h300_0000_0000; miss_en = 1'b1; tick();
        miss_en = 1'b0; tick();
        walk_ack = 1'b1; tick();
        walk_ack = 1'b0; except = 1'b1; walk_done = 1'b1; tick();
        except = 1'b0; walk_done = 1'b0;
        checks++;
        if (dut.state !== 3'd0 || dut.count !== 3'd0) begin
            errors++;
            $display("FAIL flush_same_done: state=%0d count=%0d expected 0 0", dut.state, dut.count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        miss_addr = 44'h456_789A_B000; miss_attr = 4'hC; miss_proc = 21'h12;
        miss_en = 1'b1; tick();
        miss_en = 1'b0; tick();
        walk_ack = 1'b1; tick();
        walk_ack = 1'b0; walk_done = 1'b1; tick();
        walk_done = 1'b0; tick();
        checks++;
        if (mex_en !== 1'b1 || bus_hold !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: mex_en=%b hold=%b expected 1 1", mex_en, bus_hold);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({walk_req, bus_hold, mex_en, fault_en, full, overflow} !== 6'b0 ||
            {walk_addr, mex_addr, mex_attr, fault_addr} !== '0 || dut.state !== 3'd0 || dut.count !== 3'd0) begin
            errors++;
            $display("FAIL areset_now: ctrl=%b walk_addr=%h mex_addr=%h state=%0d count=%0d expected all 0",
                     {walk_req, bus_hold, mex_en, fault_en, full, overflow}, walk_addr, mex_addr,
                     dut.state, dut.count);
        end
        tick();
        rst = 1'b1;
        tick();
        walk_done = 1'b1; walk_fault = 1'b1; tick();
        walk_done = 1'b0; walk_fault = 1'b0;
        tick();
        checks++;
        if (dut.state !== 3'd0 || walk_req !== 1'b0 || fault_en !== 1'b0 || bus_hold !== 1'b0) begin
            errors++;
            $display("FAIL areset_stale_done: state=%0d req=%b fault=%b hold=%b expected 0 0 0 0",
                     dut.state, walk_req, fault_en, bus_hold);
        end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_walk_fault();
        test_retry_exhaust();
        test_overflow();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
